dist_priority_queue: RTL and testbench

Second-generation distance store and priority queue for the Dijkstra engine. It holds a tentative distance and a visited bit for every node, and supports single-cycle distance updates and combinational distance reads. An extract-min operation is driven by a handshake: the block scans `LANES` nodes per cycle, returns the closest unvisited reachable node, and marks that node visited. Visited tracking is internal to the block, so the controller no longer passes in a predecessor vector.

---
 rtl/dist_priority_queue.sv | 188 ++++++++++++++++++
 tb/tb_dist_priority_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dist_priority_queue.sv
// Distance store and extract-min priority queue for the Dijkstra engine.
// Holds a tentative distance and a visited bit per node. Extract-min scans LANES
// nodes per cycle and marks the winner visited when the result is issued.
// Optional feature: define DIST_PQ_DECREASE_ONLY_EN to accept a set only when it
// lowers the stored distance.
module dist_priority_queue #(
    parameter int unsigned MAX_NODES   = 8,
    parameter int unsigned INDEX_WIDTH = 3,
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned LANES       = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   init_en,
    input  logic [INDEX_WIDTH-1:0] init_index,
    input  logic                   set_en,
    input  logic [INDEX_WIDTH-1:0] set_index,
    input  logic [VALUE_WIDTH-1:0] set_value,
    input  logic [INDEX_WIDTH-1:0] read_index,
    output logic [VALUE_WIDTH-1:0] read_value,
    output logic                   read_visited,
    input  logic                   pop_en,
    output logic                   busy,
    output logic                   pop_done,
    output logic                   pop_empty,
    output logic [INDEX_WIDTH-1:0] pop_index,
    output logic [VALUE_WIDTH-1:0] pop_value
);

    localparam int unsigned Groups = MAX_NODES / LANES;
    localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;
    localparam logic [VALUE_WIDTH-1:0] Inf       = '1;
    localparam logic [GrpW-1:0]        LastGroup = GrpW'(Groups - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] dist_q [MAX_NODES];
    logic [VALUE_WIDTH-1:0] dist_d [MAX_NODES];
    logic [MAX_NODES-1:0]   visited_q, visited_d;
    logic [GrpW-1:0]        grp_q, grp_d;
    logic [INDEX_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [VALUE_WIDTH-1:0] best_val_q, best_val_d;
    logic                   best_ok_q, best_ok_d;
    logic                   pop_done_q, pop_done_d;
    logic                   pop_empty_q, pop_empty_d;
    logic [INDEX_WIDTH-1:0] pop_index_q, pop_index_d;
    logic [VALUE_WIDTH-1:0] pop_value_q, pop_value_d;

    logic                   lane_ok;
    logic [INDEX_WIDTH-1:0] lane_idx;
    logic [VALUE_WIDTH-1:0] lane_val;
    logic                   cur_ok;
    logic [INDEX_WIDTH-1:0] cur_idx;
    logic [VALUE_WIDTH-1:0] cur_val;
    logic                   set_accept;

    assign read_value   = dist_q[read_index];
    assign read_visited = visited_q[read_index];
    assign busy         = (state_q == StScan);
    assign pop_done     = pop_done_q;
    assign pop_empty    = pop_empty_q;
    assign pop_index    = pop_index_q;
    assign pop_value    = pop_value_q;

    // Write acceptance; visited nodes are frozen.
`ifdef DIST_PQ_DECREASE_ONLY_EN
    assign set_accept = set_en && !visited_q[set_index] && (set_value < dist_q[set_index]);
`else
    assign set_accept = set_en && !visited_q[set_index];
`endif

    // Best qualifying lane of the current group, merged with the running best.
    always_comb begin
        logic [INDEX_WIDTH-1:0] idx;
        lane_ok  = 1'b0;
        lane_idx = '0;
        lane_val = Inf;
        for (int l = 0; l < int'(LANES); l++) begin
            idx = INDEX_WIDTH'(int'(grp_q) * int'(LANES) + l);
            // Ascending lane order with strict compare keeps ties on the lower index.
            if (!visited_q[idx] && dist_q[idx] != Inf && (!lane_ok || dist_q[idx] < lane_val)) begin
                lane_ok  = 1'b1;
                lane_idx = idx;
                lane_val = dist_q[idx];
            end
        end
        if (lane_ok && (!best_ok_q || lane_val < best_val_q)) begin
            cur_ok  = 1'b1;
            cur_idx = lane_idx;
            cur_val = lane_val;
        end else begin
            cur_ok  = best_ok_q;
            cur_idx = best_idx_q;
            cur_val = best_val_q;
        end
    end

    // Next-state: init > set > pop, scan stepping and result generation.
    always_comb begin
        state_d     = state_q;
        dist_d      = dist_q;
        visited_d   = visited_q;
        grp_d       = grp_q;
        best_idx_d  = best_idx_q;
        best_val_d  = best_val_q;
        best_ok_d   = best_ok_q;
        pop_done_d  = 1'b0;
        pop_empty_d = pop_empty_q;
        pop_index_d = pop_index_q;
        pop_value_d = pop_value_q;
        if (init_en) begin
            for (int n = 0; n < int'(MAX_NODES); n++) dist_d[n] = Inf;
            dist_d[init_index] = '0;
            visited_d = '0;
            state_d   = StIdle;
            grp_d     = '0;
            best_ok_d = 1'b0;
        end else begin
            if (set_accept) dist_d[set_index] = set_value;
            unique case (state_q)
                StIdle: begin
                    if (pop_en) begin
                        state_d   = StScan;
                        grp_d     = '0;
                        best_ok_d = 1'b0;
                    end
                end
                StScan: begin
                    if (set_accept) begin
                        // The store changed under the scan: start over.
                        grp_d     = '0;
                        best_ok_d = 1'b0;
                    end else if (grp_q == LastGroup) begin
                        state_d    = StIdle;
                        pop_done_d = 1'b1;
                        if (cur_ok) begin
                            pop_empty_d        = 1'b0;
                            pop_index_d        = cur_idx;
                            pop_value_d        = cur_val;
                            visited_d[cur_idx] = 1'b1;
                        end else begin
                            pop_empty_d = 1'b1;
                            pop_index_d = '0;
                            pop_value_d = Inf;
                        end
                    end else begin
                        grp_d      = grp_q + 1'b1;
                        best_ok_d  = cur_ok;
                        best_idx_d = cur_idx;
                        best_val_d = cur_val;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            for (int n = 0; n < int'(MAX_NODES); n++) dist_q[n] <= Inf;
            visited_q   <= '0;
            grp_q       <= '0;
            best_idx_q  <= '0;
            best_val_q  <= Inf;
            best_ok_q   <= 1'b0;
            pop_done_q  <= 1'b0;
            pop_empty_q <= 1'b0;
            pop_index_q <= '0;
            pop_value_q <= Inf;
        end else begin
            state_q     <= state_d;
            dist_q      <= dist_d;
            visited_q   <= visited_d;
            grp_q       <= grp_d;
            best_idx_q  <= best_idx_d;
            best_val_q  <= best_val_d;
            best_ok_q   <= best_ok_d;
            pop_done_q  <= pop_done_d;
            pop_empty_q <= pop_empty_d;
            pop_index_q <= pop_index_d;
            pop_value_q <= pop_value_d;
        end
    end

endmodule

// File: tb/tb_dist_priority_queue.sv
// Directed self-checking bench for dist_priority_queue (8 nodes, 2 lanes).
module tb_dist_priority_queue;

    localparam int unsigned MaxNodes = 8;
    localparam int unsigned IdxW     = 3;
    localparam int unsigned ValW     = 8;
    localparam int unsigned Lanes    = 2;
    localparam int          Inf      = 255;

    logic            clock = 1'b0;
    logic            reset;
    logic            init_en;
    logic [IdxW-1:0] init_index;
    logic            set_en;
    logic [IdxW-1:0] set_index;
    logic [ValW-1:0] set_value;
    logic [IdxW-1:0] read_index;
    logic [ValW-1:0] read_value;
    logic            read_visited;
    logic            pop_en;
    logic            busy;
    logic            pop_done;
    logic            pop_empty;
    logic [IdxW-1:0] pop_index;
    logic [ValW-1:0] pop_value;

    int n_checks = 0;
    int n_fails  = 0;

    dist_priority_queue #(
        .MAX_NODES  (MaxNodes),
        .INDEX_WIDTH(IdxW),
        .VALUE_WIDTH(ValW),
        .LANES      (Lanes)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .init_en     (init_en),
        .init_index  (init_index),
        .set_en      (set_en),
        .set_index   (set_index),
        .set_value   (set_value),
        .read_index  (read_index),
        .read_value  (read_value),
        .read_visited(read_visited),
        .pop_en      (pop_en),
        .busy        (busy),
        .pop_done    (pop_done),
        .pop_empty   (pop_empty),
        .pop_index   (pop_index),
        .pop_value   (pop_value)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input int idx, input int exp_v, input int exp_vis);
        read_index = IdxW'(idx);
        #1;
        chk({tag, "_val"}, 32'(read_value), exp_v);
        chk({tag, "_vis"}, 32'(read_visited), exp_vis);
    endtask

    task automatic do_init(input int src);
        init_en    = 1'b1;
        init_index = IdxW'(src);
        tick();
        init_en = 1'b0;
    endtask

    task automatic do_set(input int idx, input int val);
        set_en    = 1'b1;
        set_index = IdxW'(idx);
        set_value = ValW'(val);
        tick();
        set_en = 1'b0;
    endtask

    // Pop with an optional write landing on the second edge after pop_en.
    task automatic do_pop(input string tag, input int exp_lat, input int exp_empty,
                          input int exp_idx, input int exp_val,
                          input bit inj, input int inj_idx, input int inj_val);
        int lat;
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 1);
        lat = 0;
        if (inj) begin
            tick();
            lat = 1;
            set_en    = 1'b1;
            set_index = IdxW'(inj_idx);
            set_value = ValW'(inj_val);
            tick();
            set_en = 1'b0;
            lat = 2;
        end
        while (pop_done !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy_done"}, 32'(busy), 0);
        chk({tag, "_empty"}, 32'(pop_empty), exp_empty);
        chk({tag, "_idx"}, 32'(pop_index), exp_idx);
        chk({tag, "_val"}, 32'(pop_value), exp_val);
        tick();
        chk({tag, "_pulse"}, 32'(pop_done), 0);
        chk({tag, "_hold"}, 32'(pop_index), exp_idx);
    endtask

    initial begin
        int seen;
        reset = 1'b1; init_en = 1'b0; init_index = '0; set_en = 1'b0;
        set_index = '0; set_value = '0; read_index = '0; pop_en = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(pop_done), 0);
        chk("rst_empty", 32'(pop_empty), 0);
        chk("rst_idx", 32'(pop_index), 0);
        chk("rst_val", 32'(pop_value), Inf);
        rd("rst_n0", 0, Inf, 0);
        rd("rst_n7", 7, Inf, 0);

        // Init with source 3 and a single pop
        do_init(3);
        rd("init_n3", 3, 0, 0);
        rd("init_n5", 5, Inf, 0);
        do_pop("pop_src3", 4, 0, 3, 0, 1'b0, 0, 0);
        rd("vis_n3", 3, 0, 1);

        // Visited node ignores writes and is never returned again
        do_set(3, 1);
        rd("prot_n3", 3, 0, 1);
        do_set(4, 5);
        do_pop("pop_prot", 4, 0, 4, 5, 1'b0, 0, 0);

        // Ordering and tie-break
        do_init(0);
        do_pop("pop_src0", 4, 0, 0, 0, 1'b0, 0, 0);
        do_set(5, 7);
        do_set(2, 7);
        do_set(6, 4);
        do_pop("pop_n6", 4, 0, 6, 4, 1'b0, 0, 0);
        do_pop("pop_n2", 4, 0, 2, 7, 1'b0, 0, 0);
        do_pop("pop_n5", 4, 0, 5, 7, 1'b0, 0, 0);
        do_pop("pop_empty", 4, 1, 0, Inf, 1'b0, 0, 0);

        // Restart: node 1 written after group 0 was already scanned
        do_init(0);
        do_pop("pop_src0b", 4, 0, 0, 0, 1'b0, 0, 0);
        do_set(4, 20);
        do_set(7, 20);
        do_pop("pop_restart", 6, 0, 1, 9, 1'b1, 1, 9);

        // Decrease-only behaviour
        do_set(5, 10);
        do_set(5, 12);
`ifdef DIST_PQ_DECREASE_ONLY_EN
        rd("dec_n5", 5, 10, 0);
        do_pop("pop_dec", 4, 0, 5, 10, 1'b1, 5, 15);
`else
        rd("dec_n5", 5, 12, 0);
        do_pop("pop_dec", 6, 0, 5, 15, 1'b1, 5, 15);
`endif

        // Abort a scan with init
        pop_en = 1'b1;
        tick();
        pop_en = 1'b0;
        tick();
        chk("abort_busy_pre", 32'(busy), 1);
        do_init(6);
        chk("abort_busy", 32'(busy), 0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (pop_done === 1'b1) seen++;
            tick();
        end
        chk("abort_no_done", seen, 0);
        for (int n = 0; n < int'(MaxNodes); n++) begin
            rd($sformatf("abort_n%0d", n), n, (n == 6) ? 0 : Inf, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
